// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 serial transmitter (start, 8 data bits LSB first, stop)
// fed by a single-entry valid/ready byte handshake; all outputs registered.
module uart_tx_8n1 #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);
   localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q;
   logic          tx_q, ready_q, busy_q;
   logic          bit_end;
   assign bit_end  = baud_q == LAST;
   assign idx_d    = idx_q + 3'd1;
   assign tx_ready = ready_q;
   assign tx       = tx_q;
   assign busy     = busy_q;
   // tx_q is loaded with the next bit on the same edge that ends the current one
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
         case (state_q)
            IDLE:
               if (tx_valid && ready_q) begin
                  shift_q <= tx_data;
                  idx_q   <= '0;
                  tx_q    <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= START;
               end
            START:
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end
            DATA:
               if (bit_end) begin
                  if (idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     idx_q <= idx_d;
                     tx_q  <= shift_q[idx_d];
                  end
               end
            STOP:
               if (bit_end) begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            default: state_q <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1: table-driven and hand-written sequences against a frame-level
// line model and a mid-bit sampling UART receiver model.
module tb_uart_tx_8n1;
   localparam int C  = 4;
   localparam int CD = 434;
   logic       clk = 1'b0, rst_n = 1'b1;
   logic [7:0] d4 = '0, dd = '0;
   logic       v4 = 1'b0, vd = 1'b0;
   logic       r4, t4, b4, rd, td, bd;
   int         checks = 0, errors = 0;
   logic [7:0] rxq[$];
   int         ferr = 0, gap = 0;

   uart_tx_8n1 #(.CLKS_PER_BIT(C)) dut4 (.clk(clk), .rst_n(rst_n), .tx_data(d4), .tx_valid(v4),
      .tx_ready(r4), .tx(t4), .busy(b4));
   uart_tx_8n1 dutd (.clk(clk), .rst_n(rst_n), .tx_data(dd), .tx_valid(vd),
      .tx_ready(rd), .tx(td), .busy(bd));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rx_at(input int i);
      return rxq.size() > i ? 32'(rxq[i]) : 32'hFFFF_FFFF;
   endfunction

   // receiver model: samples each bit at its middle, records high run before each frame
   initial begin
      int t, hi;
      logic act;
      logic [7:0] sh;
      act = 1'b0; hi = 0; t = 0; sh = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            act = 1'b0;
            hi  = 0;
         end else if (!act && t4 === 1'b0) begin
            act = 1'b1; t = 0; gap = hi; hi = 0;
         end else if (!act) hi++;
         if (act && rst_n) begin
            if (t % C == C / 2 && t / C >= 1 && t / C <= 8) sh[t / C - 1] = t4;
            if (t == 9 * C + C / 2) begin
               if (t4 !== 1'b1) ferr++;
               rxq.push_back(sh);
            end
            if (t == 10 * C - 1) begin
               act = 1'b0;
               hi  = C;
            end
            t++;
         end
      end
   end

   task automatic send4(input logic [7:0] data, input string name, output int lows);
      int bad;
      logic [9:0] fr;
      fr = {1'b1, data, 1'b0};
      bad = 0;
      lows = 0;
      @(negedge clk);
      chk({name, "_ready_before"}, 32'(r4), 32'd1);
      d4 = data;
      v4 = 1'b1;
      @(posedge clk);
      #1 v4 = 1'b0;
      d4 = 8'($urandom);
      for (int t = 0; t < 10 * C; t++) begin
         @(negedge clk);
         if (t4 === 1'b0) lows++;
         if ({t4, r4, b4} !== {fr[t / C], 2'b01}) bad++;
      end
      chk({name, "_bad_cycles"}, 32'(bad), 32'd0);
      @(negedge clk);
      chk({name, "_idle_after_frame"}, 32'({t4, r4, b4}), 32'b110);
   endtask

   typedef struct {
      logic [7:0] data;
      int         idle;
      logic [7:0] exp_byte;
      int         exp_lows;
   } vec_t;

   initial begin
      vec_t tbl[12];
      int lows, n, bad;
      logic [7:0] r;
      // reset asserted between edges must act immediately on both instances
      #2 rst_n = 1'b0;
      #1 chk("reset_async_4", 32'({t4, r4, b4}), 32'b110);
      chk("reset_async_dflt", 32'({td, rd, bd}), 32'b110);
      repeat (3) @(negedge clk);
      chk("reset_held", 32'({t4, r4, b4, td, rd, bd}), 32'b110110);
      rst_n = 1'b1;

      tbl[0] = '{8'h55, 0, 8'h55, 20};
      tbl[1] = '{8'h00, 3, 8'h00, 36};
      tbl[2] = '{8'hFF, 1, 8'hFF, 4};
      tbl[3] = '{8'h80, 0, 8'h80, 32};
      for (int i = 4; i < 12; i++) begin
         r = 8'($urandom);
         tbl[i] = '{r, int'($urandom_range(0, 5)), r, C * (9 - $countones(r))};
      end
      for (int i = 0; i < 12; i++) begin
         repeat (tbl[i].idle) @(negedge clk);
         rxq.delete();
         send4(tbl[i].data, $sformatf("vec%0d", i), lows);
         chk($sformatf("vec%0d_low_cycles", i), 32'(lows), 32'(tbl[i].exp_lows));
         chk($sformatf("vec%0d_rx_count", i), 32'(rxq.size()), 32'd1);
         chk($sformatf("vec%0d_rx_byte", i), rx_at(0), 32'(tbl[i].exp_byte));
      end

      // back-to-back with tx_valid held high
      rxq.delete();
      @(negedge clk);
      d4 = 8'hA3;
      v4 = 1'b1;
      @(posedge clk);
      #1 d4 = 8'h0F;
      n = 0;
      do begin @(negedge clk); n++; end while (r4 !== 1'b1 && n < 100);
      chk("b2b_first_ready", 32'(n), 32'(10 * C + 1));
      @(negedge clk);
      chk("b2b_second_accept", 32'({t4, r4, b4}), 32'b001);
      v4 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (r4 !== 1'b1 && n < 100);
      chk("b2b_second_ready", 32'(n), 32'(10 * C));
      repeat (2) @(negedge clk);
      chk("b2b_rx_count", 32'(rxq.size()), 32'd2);
      chk("b2b_byte0", rx_at(0), 32'hA3);
      chk("b2b_byte1", rx_at(1), 32'h0F);
      chk("b2b_gap", 32'(gap), 32'(C + 1));

      // valid toggling and data changes while busy
      rxq.delete();
      @(negedge clk);
      d4 = 8'h81;
      v4 = 1'b1;
      @(posedge clk);
      #1 d4 = 8'hFF;
      bad = 0;
      for (int t = 0; t < 10 * C; t++) begin
         @(negedge clk);
         if (r4 !== 1'b0 || b4 !== 1'b1) bad++;
         v4 = t < 10 * C - 1 ? 1'($urandom) : 1'b0;
      end
      repeat (50) @(negedge clk);
      chk("abuse_ready_low", 32'(bad), 32'd0);
      chk("abuse_rx_count", 32'(rxq.size()), 32'd1);
      chk("abuse_rx_byte", rx_at(0), 32'h81);
      chk("abuse_idle", 32'({t4, r4, b4}), 32'b110);

      // reset during data bit 3 of 0xC3
      @(negedge clk);
      d4 = 8'hC3;
      v4 = 1'b1;
      @(posedge clk);
      #1 v4 = 1'b0;
      repeat (4 * C + 1) @(negedge clk);
      chk("c3_bit3_low", 32'(t4), 32'd0);
      #2 rst_n = 1'b0;
      #1 chk("midframe_reset_async", 32'({t4, r4, b4}), 32'b110);
      repeat (3) @(negedge clk);
      chk("midframe_reset_held", 32'({t4, r4, b4}), 32'b110);
      rst_n = 1'b1;
      rxq.delete();
      send4(8'h3C, "post_reset", lows);
      chk("post_reset_rx_count", 32'(rxq.size()), 32'd1);
      chk("post_reset_rx_byte", rx_at(0), 32'h3C);
      chk("framing_errors", 32'(ferr), 32'd0);

      // default rate, byte 0x00
      @(negedge clk);
      dd = 8'h00;
      vd = 1'b1;
      @(posedge clk);
      #1 vd = 1'b0;
      n = 0;
      lows = 0;
      do begin
         @(negedge clk);
         n++;
         if (td === 1'b0) lows++;
      end while (rd !== 1'b1 && n < 5000);
      chk("dflt_low_cycles", 32'(lows), 32'(9 * CD));
      chk("dflt_cycles_to_ready", 32'(n - 1), 32'(10 * CD));
      chk("dflt_idle", 32'({td, rd, bd}), 32'b110);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
